// File: rtl/matmul_stream_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matmul_stream_loader_if : element stream in, operand arrays out            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface matmul_stream_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 32,
  parameter int M          = 32,
  parameter int Q          = 32
);
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(M);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [ACC_W-1:0]      mat1 [N][M];
  logic [ACC_W-1:0]      mat2 [M][Q];
  logic                  mats_valid;
  logic                  mats_ack;
  logic                  err;

  modport master (
    output in_valid, in_data, in_last, mats_ack,
    input  in_ready, mat1, mat2, mats_valid, err
  );

  modport slave (
    input  in_valid, in_data, in_last, mats_ack,
    output in_ready, mat1, mat2, mats_valid, err
  );
endinterface
`default_nettype wire

// File: rtl/matmul_stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matmul_stream_loader : assembles a serial element stream into mat1/mat2    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module matmul_stream_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 32,
  parameter int M          = 32,
  parameter int Q          = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  matmul_stream_loader_if.slave  ld_bus
);
  localparam int ACC_W  = 2*DATA_WIDTH + $clog2(M);
  localparam int MAX_NM = (N > M) ? N : M;
  localparam int MAX_D  = (MAX_NM > Q) ? MAX_NM : Q;
  localparam int CW     = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             err_q, err_d;
  logic             wr_a, wr_b;
  logic             ready;
  logic             beat;
  logic             last_a, last_b;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] mat1_q [N][M];
  logic [ACC_W-1:0] mat2_q [M][Q];

  assign ready  = !reset && (state_q != HOLD);
  assign beat   = ld_bus.in_valid && ready;
  assign last_a = (row_q == CW'(N-1)) && (col_q == CW'(M-1));
  assign last_b = (row_q == CW'(M-1)) && (col_q == CW'(Q-1));
  assign ext    = {{(ACC_W-DATA_WIDTH){ld_bus.in_data[DATA_WIDTH-1]}}, ld_bus.in_data};

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    case (state_q)
      FILL_A: begin
        if (beat) begin
          if (ld_bus.in_last) begin
            err_d = 1'b1;
            row_d = '0;
            col_d = '0;
          end else begin
            wr_a = 1'b1;
            if (last_a) begin
              state_d = FILL_B;
              row_d   = '0;
              col_d   = '0;
            end else if (col_q == CW'(M-1)) begin
              row_d = row_q + CW'(1);
              col_d = '0;
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      FILL_B: begin
        if (beat) begin
          if (ld_bus.in_last && !last_b) begin
            err_d   = 1'b1;
            state_d = FILL_A;
            row_d   = '0;
            col_d   = '0;
          end else begin
            wr_b = 1'b1;
            if (last_b) begin
              // A missing in_last still completes the pair, but is flagged.
              state_d = HOLD;
              err_d   = !ld_bus.in_last;
              row_d   = '0;
              col_d   = '0;
            end else if (col_q == CW'(Q-1)) begin
              row_d = row_q + CW'(1);
              col_d = '0;
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (ld_bus.mats_ack) begin
          state_d = FILL_A;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = FILL_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL_A;
      row_q   <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < M; c++)
          mat1_q[r][c] <= '0;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < Q; c++)
          mat2_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      err_q   <= err_d;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < M; c++)
          if (wr_a && (row_q == CW'(r)) && (col_q == CW'(c)))
            mat1_q[r][c] <= ext;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < Q; c++)
          if (wr_b && (row_q == CW'(r)) && (col_q == CW'(c)))
            mat2_q[r][c] <= ext;
    end
  end

  assign ld_bus.in_ready   = ready;
  assign ld_bus.mats_valid = (state_q == HOLD);
  assign ld_bus.err        = err_q;
  assign ld_bus.mat1       = mat1_q;
  assign ld_bus.mat2       = mat2_q;
endmodule
`default_nettype wire

// File: tb/tb_matmul_stream_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matmul_stream_loader : randomized stream vs frame-level reference model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_matmul_stream_loader;
  localparam int DW    = 16;
  localparam int N     = 4;
  localparam int M     = 4;
  localparam int Q     = 4;
  localparam int ACC_W = 2*DW + $clog2(M);
  localparam int NA    = N*M;
  localparam int TOTAL = N*M + M*Q;

  typedef logic [TOTAL*ACC_W-1:0] frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matmul_stream_loader_if #(.DATA_WIDTH(DW), .N(N), .M(M), .Q(Q)) bus ();

  matmul_stream_loader #(.DATA_WIDTH(DW), .N(N), .M(M), .Q(Q)) dut (
    .clk    (clk),
    .reset  (reset),
    .ld_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: flat element position within the current pair.
  logic [ACC_W-1:0] em [TOTAL];
  int     pos      = 0;
  bit     exp_hold = 1'b0;
  bit     exp_err  = 1'b0;
  frame_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ACC_W-1:0] sext(input logic [DW-1:0] d);
    return ACC_W'($signed(d));
  endfunction

  function automatic logic [ACC_W-1:0] dut_elem(input int k);
    if (k < NA) return bus.mat1[k/M][k%M];
    return bus.mat2[(k-NA)/Q][(k-NA)%Q];
  endfunction

  task automatic check_live(input string name);
    for (int k = 0; k < TOTAL; k++) check(name, 64'(dut_elem(k)), 64'(em[k]));
  endtask

  // One clock of stimulus; the model advances at the same edge the DUT does.
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic l, input logic ack);
    frame_t f;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.mats_ack = ack;
    @(negedge clk);
    check("in_ready", 64'(bus.in_ready), 64'(!exp_hold));
    check("mats_valid", 64'(bus.mats_valid), 64'(exp_hold));
    check("err", 64'(bus.err), 64'(exp_err));
    @(posedge clk);
    exp_err = 1'b0;
    if (exp_hold) begin
      if (ack) exp_hold = 1'b0;
    end else if (v) begin
      if (l && pos != TOTAL-1) begin
        exp_err = 1'b1;
        pos     = 0;
      end else begin
        em[pos] = sext(d);
        if (pos == TOTAL-1) begin
          for (int k = 0; k < TOTAL; k++) f[k*ACC_W +: ACC_W] = em[k];
          exp_q.push_back(f);
          exp_hold = 1'b1;
          exp_err  = !l;
          pos      = 0;
        end else begin
          pos++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.mats_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
    check("mats_valid_in_reset", 64'(bus.mats_valid), 64'd0);
    check("err_in_reset", 64'(bus.err), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < TOTAL; k++) em[k] = '0;
    pos      = 0;
    exp_hold = 1'b0;
    exp_err  = 1'b0;
    exp_q.delete();
    check_live("reset_contents");
  endtask

  function automatic logic [DW-1:0] gen_data(input int mode, input int b);
    if (mode == 0) return DW'(b);
    if (mode == 2) begin
      case ((b-1) % 4)
        0:       return 16'hFFFF;
        1:       return 16'h8000;
        2:       return 16'h7FFF;
        default: return DW'($urandom);
      endcase
    end
    return DW'($urandom);
  endfunction

  // last_at: beat carrying in_last (0 = none); stop_at: abandon after that beat.
  task automatic send_frame(input int mode, input int gap_pct, input int last_at, input int stop_at);
    int b = 1;
    while (b <= TOTAL) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        tick(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        tick(1'b1, gen_data(mode, b), (b == last_at), ($urandom_range(0, 3) == 0));
        if ((b == last_at && last_at < TOTAL) || b == stop_at) break;
        b++;
      end
    end
  endtask

  task automatic hold_and_ack(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b1, DW'($urandom), 1'($urandom), 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: pops the expected pair on each rising mats_valid, then watches it stay frozen.
  initial begin
    frame_t held;
    bit     prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.mats_valid) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got mats_valid=1 expected no pending pair at %0t", $time);
          end else begin
            held = exp_q.pop_front();
            for (int k = 0; k < TOTAL; k++)
              check("frame_elem", 64'(dut_elem(k)), 64'(held[k*ACC_W +: ACC_W]));
          end
        end else begin
          for (int k = 0; k < TOTAL; k++)
            check("hold_stable", 64'(dut_elem(k)), 64'(held[k*ACC_W +: ACC_W]));
        end
      end
      prev = !reset && bus.mats_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_at;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.mats_ack = 1'b0;
    do_reset();

    // Back-to-back 1..32, then hold with in_valid high.
    send_frame(0, 0, TOTAL, 0);
    check("m1_1_2", 64'(bus.mat1[1][2]), 64'd7);
    check("m2_3_3", 64'(bus.mat2[3][3]), 64'd32);
    hold_and_ack(10);

    // Sign extension corner values.
    send_frame(2, 0, TOTAL, 0);
    check("sext_neg1", 64'(bus.mat1[0][0]), 64'({ACC_W{1'b1}}));
    check("sext_min", 64'(bus.mat1[0][1]), 64'({{(ACC_W-DW){1'b1}}, 16'h8000}));
    check("sext_max", 64'(bus.mat1[0][2]), 64'h7FFF);
    hold_and_ack(3);

    // Early in_last on beat 7; earlier writes stay, then a clean frame.
    send_frame(1, 0, 7, 0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check_live("after_early_last");
    send_frame(1, 0, TOTAL, 0);
    hold_and_ack(2);

    // Missing in_last on the final beat.
    send_frame(1, 0, 0, 0);
    hold_and_ack(2);

    // Gaps, reset at beat 20, then a full frame with gaps.
    send_frame(1, 30, TOTAL, 20);
    do_reset();
    send_frame(1, 30, TOTAL, 0);
    hold_and_ack(4);

    // Reset while holding.
    send_frame(1, 0, TOTAL, 0);
    tick(1'b1, '0, 1'b0, 1'b0);
    do_reset();

    for (int f = 0; f < 12; f++) begin
      last_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TOTAL-1)) : TOTAL;
      send_frame(1, int'($urandom_range(0, 40)), last_at, 0);
      if (last_at == TOTAL) hold_and_ack(int'($urandom_range(0, 5)));
    end
    tick(1'b0, '0, 1'b0, 1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
